// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants for the ID-stage control units.
// Stall-count defaults are common to the branch resolver and the load-use hazard unit.
package mips_pkg;

  typedef enum logic {
    RESOLVE = 1'b0,
    STALL   = 1'b1
  } br_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int ALU_STALL_DEF      = 1;
  localparam int LOAD_STALL_DEF     = 2;
  localparam int MEM_LOAD_STALL_DEF = 1;

endpackage

// File: rtl/branch_hazard_detect.sv
// Branch operand hazard detect: flags EX/MEM producers of rs/rt and picks the extra stall length.
// Purely combinational, zero latency; no backpressure of its own.
module branch_hazard_detect
  import mips_pkg::*;
#(
  parameter int REG_W          = 5,
  parameter int ALU_STALL      = ALU_STALL_DEF,
  parameter int LOAD_STALL     = LOAD_STALL_DEF,
  parameter int MEM_LOAD_STALL = MEM_LOAD_STALL_DEF
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_memread,
  input  logic [REG_W-1:0] mem_rd,
  output logic             hazard_ex,
  output logic             hazard_mem,
  output logic [1:0]       stall_len
);

  // $0 is hardwired, so a write to it never blocks a branch operand.
  assign hazard_ex  = ex_regwrite & (ex_rd != REG_W'(REG_ZERO)) &
                      ((ex_rd == id_rs) | (ex_rd == id_rt));
  assign hazard_mem = mem_memread & (mem_rd != REG_W'(REG_ZERO)) &
                      ((mem_rd == id_rs) | (mem_rd == id_rt));

  // Cycles still needed after the current one; EX hazard wins over MEM.
  always_comb begin
    stall_len = 2'd0;
    if (hazard_ex) begin
      stall_len = ex_memread ? 2'(LOAD_STALL - 1) : 2'(ALU_STALL - 1);
    end else if (hazard_mem) begin
      stall_len = 2'(MEM_LOAD_STALL - 1);
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// ID-stage branch resolution: stalls until rs/rt are forwardable, then drives PC redirect and IF/ID flush.
// Latency 0 (no hazard) to 2 (load in EX) cycles; stall holds the front end. Optional: BRANCH_RESOLVE_STATS_EN.
module branch_resolve
  import mips_pkg::*;
#(
  parameter int REG_W          = 5,
  parameter int ALU_STALL      = ALU_STALL_DEF,
  parameter int LOAD_STALL     = LOAD_STALL_DEF,
  parameter int MEM_LOAD_STALL = MEM_LOAD_STALL_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_beq,
  input  logic             id_bne,
  input  logic             eq,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_memread,
  input  logic [REG_W-1:0] mem_rd,
  output logic             stall,
  output logic             pc_src,
  output logic             flush_ifid
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [31:0]      br_count,
  output logic [31:0]      br_taken_count
`endif
);

  br_state_t  state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       br, taken, resolve;
  logic       hazard_ex, hazard_mem;
  logic [1:0] stall_len;
  logic       stall_c, pc_src_c;

  assign br    = id_beq | id_bne;
  assign taken = eq ^ id_bne;

  branch_hazard_detect #(
    .REG_W         (REG_W),
    .ALU_STALL     (ALU_STALL),
    .LOAD_STALL    (LOAD_STALL),
    .MEM_LOAD_STALL(MEM_LOAD_STALL)
  ) u_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .ex_regwrite(ex_regwrite),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .mem_memread(mem_memread),
    .mem_rd     (mem_rd),
    .hazard_ex  (hazard_ex),
    .hazard_mem (hazard_mem),
    .stall_len  (stall_len)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    pc_src_c = 1'b0;
    resolve  = 1'b0;
    case (state_q)
      RESOLVE: begin
        if (br) begin
          if (hazard_ex | hazard_mem) begin
            stall_c = 1'b1;
            cnt_d   = stall_len;
            state_d = (stall_len == 2'd0) ? RESOLVE : STALL;
          end else begin
            resolve  = 1'b1;
            pc_src_c = taken;
          end
        end
      end
      STALL: begin
        // A killed branch or the final hold cycle both hand back to RESOLVE.
        stall_c = 1'b1;
        if (!br || cnt_q <= 2'd1) begin
          state_d = RESOLVE;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = RESOLVE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESOLVE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are combinational from live inputs, so they are masked while in reset.
  assign stall      = rst_n & stall_c;
  assign pc_src     = rst_n & pc_src_c;
  assign flush_ifid = rst_n & pc_src_c;

`ifdef BRANCH_RESOLVE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count       <= 32'd0;
      br_taken_count <= 32'd0;
    end else if (resolve) begin
      br_count <= br_count + 32'd1;
      if (taken) begin
        br_taken_count <= br_taken_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed vector table, multi-cycle sequences, then random traffic vs a stall-budget model.
module tb_branch_resolve;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_beq, id_bne, eq;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       ex_regwrite, ex_memread, mem_memread;
  logic       stall, pc_src, flush_ifid;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] br_count, br_taken_count;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  branch_resolve dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_beq     (id_beq),
    .id_bne     (id_bne),
    .eq         (eq),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .ex_regwrite(ex_regwrite),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .mem_memread(mem_memread),
    .mem_rd     (mem_rd),
    .stall      (stall),
    .pc_src     (pc_src),
    .flush_ifid (flush_ifid)
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    .br_count      (br_count),
    .br_taken_count(br_taken_count)
`endif
  );

  typedef struct {
    logic       beq, bne, eq;
    logic [4:0] rs, rt;
    logic       ex_rw, ex_mr;
    logic [4:0] ex_rd;
    logic       mem_mr;
    logic [4:0] mem_rd;
    logic       exp_stall, exp_pc;
  } vec_t;

  function automatic vec_t mk(int beq, int bne, int e, int rs, int rt, int exrw, int exmr,
                              int exrd, int memmr, int memrd, int st, int pc);
    vec_t v;
    v.beq = 1'(beq); v.bne = 1'(bne); v.eq = 1'(e);
    v.rs = 5'(rs); v.rt = 5'(rt);
    v.ex_rw = 1'(exrw); v.ex_mr = 1'(exmr); v.ex_rd = 5'(exrd);
    v.mem_mr = 1'(memmr); v.mem_rd = 5'(memrd);
    v.exp_stall = 1'(st); v.exp_pc = 1'(pc);
    return v;
  endfunction

  task automatic drive(vec_t v);
    id_beq = v.beq; id_bne = v.bne; eq = v.eq;
    id_rs = v.rs; id_rt = v.rt;
    ex_regwrite = v.ex_rw; ex_memread = v.ex_mr; ex_rd = v.ex_rd;
    mem_memread = v.mem_mr; mem_rd = v.mem_rd;
  endtask

  task automatic chk(string name, logic act, logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic chk_out(string name, logic exp_stall, logic exp_pc);
    chk({name, ".stall"}, stall, exp_stall);
    chk({name, ".pc_src"}, pc_src, exp_pc);
    chk({name, ".flush"}, flush_ifid, exp_pc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Total hold cycles a branch needs before its operands are forwardable.
  function automatic int need_cycles(vec_t v);
    bit hz_ex, hz_mem;
    hz_ex  = v.ex_rw && v.ex_rd != 0 && (v.ex_rd == v.rs || v.ex_rd == v.rt);
    hz_mem = v.mem_mr && v.mem_rd != 0 && (v.mem_rd == v.rs || v.mem_rd == v.rt);
    if (hz_ex) return v.ex_mr ? 2 : 1;
    if (hz_mem) return 1;
    return 0;
  endfunction

  vec_t vecs[12];
  vec_t idle_v;

  initial begin
    int rem;
    int n;
    int m_cnt, m_taken;
    logic e_stall, e_pc;
    vec_t r;

    idle_v = mk(0,0,0, 0,0, 0,0,0, 0,0, 0,0);
    //             beq bne eq rs rt exrw exmr exrd memmr memrd  stall pc
    vecs[0]  = mk(1,0,1, 3,4, 0,0,0, 0,0, 0,1);
    vecs[1]  = mk(0,1,1, 3,4, 0,0,0, 0,0, 0,0);
    vecs[2]  = mk(0,1,0, 3,4, 0,0,0, 0,0, 0,1);
    vecs[3]  = mk(1,0,0, 3,4, 0,0,0, 0,0, 0,0);
    vecs[4]  = mk(1,0,1, 5,4, 1,0,5, 0,0, 1,0);
    vecs[5]  = mk(1,0,1, 3,7, 1,1,7, 0,0, 1,0);
    vecs[6]  = mk(1,0,1, 0,4, 1,0,0, 0,0, 0,1);
    vecs[7]  = mk(1,0,1, 3,4, 0,0,0, 1,4, 1,0);
    vecs[8]  = mk(0,0,1, 5,5, 1,1,5, 1,5, 0,0);
    vecs[9]  = mk(1,0,1, 0,2, 0,0,0, 1,0, 0,1);
    vecs[10] = mk(0,1,0, 6,2, 0,0,6, 0,0, 0,1);
    vecs[11] = mk(1,0,1, 6,2, 0,1,6, 0,0, 0,1);

    // Reset with a hazarding branch presented: outputs must still be quiet.
    rst_n = 1'b0;
    drive(vecs[5]);
    #3;
    chk_out("reset", 1'b0, 1'b0);
    step();
    drive(idle_v);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #2;
      chk_out($sformatf("vec%0d", i), vecs[i].exp_stall, vecs[i].exp_pc);
      step();
      drive(idle_v);
      step();
    end

    // ALU producer in EX: one stall cycle, then resolves taken.
    drive(mk(1,0,1, 5,4, 1,0,5, 0,0, 0,0)); #2; chk_out("alu.c0", 1'b1, 1'b0); step();
    drive(mk(1,0,1, 5,4, 0,0,0, 0,0, 0,0)); #2; chk_out("alu.c1", 1'b0, 1'b1); step();

    // Load producer in EX: exactly two stall cycles; hazard inputs ignored while held.
    drive(mk(1,0,1, 3,7, 1,1,7, 0,0, 0,0)); #2; chk_out("ld.c0", 1'b1, 1'b0); step();
    drive(mk(1,0,1, 3,7, 1,1,7, 0,0, 0,0)); #2; chk_out("ld.c1", 1'b1, 1'b0); step();
    drive(mk(1,0,1, 3,7, 0,0,0, 0,0, 0,0)); #2; chk_out("ld.c2", 1'b0, 1'b1); step();
    drive(idle_v); step();

    // Reset during the first cycle of a load stall.
    drive(mk(1,0,1, 3,7, 1,1,7, 0,0, 0,0)); #2; chk_out("rst.c0", 1'b1, 1'b0);
    rst_n = 1'b0; #1; chk_out("rst.low", 1'b0, 1'b0);
    step();
    drive(mk(1,0,1, 3,7, 0,0,0, 0,0, 0,0)); rst_n = 1'b1; #2;
    chk_out("rst.after", 1'b0, 1'b1);
    step();

    // Branch killed while held: stall drops on the following cycle.
    drive(mk(1,0,1, 3,7, 1,1,7, 0,0, 0,0)); #2; chk_out("kill.c0", 1'b1, 1'b0); step();
    drive(idle_v); #2; chk_out("kill.c1", 1'b1, 1'b0); step();
    drive(idle_v); #2; chk_out("kill.c2", 1'b0, 1'b0); step();

    // Random traffic against a remaining-hold-cycles model.
    rst_n = 1'b0; rem = 0; m_cnt = 0; m_taken = 0;
    step();
    rst_n = 1'b1;
`ifdef BRANCH_RESOLVE_STATS_EN
    chk32("stats.rst", br_count, 32'd0);
`endif
    for (int c = 0; c < 400; c++) begin
      n = int'($urandom_range(0, 2));
      r = mk(n == 1, n == 2, int'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 0, 0);
      drive(r);
      e_stall = 1'b0;
      e_pc    = 1'b0;
      if (rem > 0) begin
        e_stall = 1'b1;
        rem = (r.beq || r.bne) ? rem - 1 : 0;
      end else if (r.beq || r.bne) begin
        n = need_cycles(r);
        if (n > 0) begin
          e_stall = 1'b1;
          rem = n - 1;
        end else begin
          e_pc = r.eq ^ r.bne;
          m_cnt++;
          if (e_pc) m_taken++;
        end
      end
      #2;
      if (stall !== e_stall || pc_src !== e_pc || flush_ifid !== e_pc)
        chk_out($sformatf("rand%0d", c), e_stall, e_pc);
      else begin
        total++;
        passed++;
      end
      step();
    end
    drive(idle_v);
    step();
`ifdef BRANCH_RESOLVE_STATS_EN
    chk32("stats.count", br_count, 32'(m_cnt));
    chk32("stats.taken", br_taken_count, 32'(m_taken));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
